// File: rtl/cordic_sincos_if.sv
// Request/status bundle for cordic_sincos: start, angle, result select, busy and done.
// The master drives the request side; the slave (the CORDIC core) reports status.
interface cordic_sincos_if;
  logic               st;
  logic signed [15:0] angle_in;
  logic [3:0]         func;
  logic               busy;
  logic               done;

  modport master (output st, angle_in, func, input busy, done);
  modport slave  (input st, angle_in, func, output busy, done);
endinterface

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC sin/cos in Q2.14, one iteration per clock.
// Define CORDIC_ANGLE_CLAMP_EN to clamp the loaded angle to +/- pi/2.
module cordic_sincos #(
  parameter int unsigned N = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  cordic_sincos_if.slave    bus,
  output wire        [31:0] result
);

  localparam logic signed [15:0] KInit    = 16'sd9949;
  localparam logic signed [15:0] AngleMax = 16'sd25736;
  localparam logic [4:0]         LastIter = 5'(N - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e             state_q;
  logic signed [15:0] x_q, y_q, z_q;
  logic [4:0]         i_q;
  logic               busy_q, done_q;

  logic signed [15:0] atan_i, x_sh, y_sh, x_nxt, y_nxt, z_nxt, load_z;
  logic               sel;
  logic [31:0]        res_val;

  // round(atan(2^-i) * 16384)
  always_comb begin
    case (i_q[3:0])
      4'd0:    atan_i = 16'sd12868;
      4'd1:    atan_i = 16'sd7596;
      4'd2:    atan_i = 16'sd4014;
      4'd3:    atan_i = 16'sd2037;
      4'd4:    atan_i = 16'sd1023;
      4'd5:    atan_i = 16'sd512;
      4'd6:    atan_i = 16'sd256;
      4'd7:    atan_i = 16'sd128;
      4'd8:    atan_i = 16'sd64;
      4'd9:    atan_i = 16'sd32;
      4'd10:   atan_i = 16'sd16;
      4'd11:   atan_i = 16'sd8;
      4'd12:   atan_i = 16'sd4;
      4'd13:   atan_i = 16'sd2;
      4'd14:   atan_i = 16'sd1;
      default: atan_i = 16'sd0;
    endcase
  end

  // z sign picks rotation direction; all sums wrap in 16 bits.
  always_comb begin
    x_sh = x_q >>> i_q[3:0];
    y_sh = y_q >>> i_q[3:0];
    if (z_q[15]) begin
      x_nxt = x_q + y_sh;
      y_nxt = y_q - x_sh;
      z_nxt = z_q + atan_i;
    end else begin
      x_nxt = x_q - y_sh;
      y_nxt = y_q + x_sh;
      z_nxt = z_q - atan_i;
    end
  end

  always_comb begin
    load_z = bus.angle_in;
`ifdef CORDIC_ANGLE_CLAMP_EN
    if (bus.angle_in > AngleMax) begin
      load_z = AngleMax;
    end else if (bus.angle_in < -AngleMax) begin
      load_z = -AngleMax;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (bus.st) begin
            x_q     <= KInit;
            y_q     <= '0;
            z_q     <= load_z;
            i_q     <= '0;
            state_q <= StRun;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StRun: begin
          x_q <= x_nxt;
          y_q <= y_nxt;
          z_q <= z_nxt;
          i_q <= i_q + 5'd1;
          if (i_q == LastIter) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_comb begin
    res_val = '0;
    if (done_q) begin
      res_val = (bus.func == 4'd0) ? {{16{y_q[15]}}, y_q} : {{16{x_q[15]}}, x_q};
    end
  end

  assign sel    = (bus.func == 4'd0) || (bus.func == 4'd1);
  assign result = sel ? res_val : 32'bz;

endmodule

// File: tb/tb_cordic_sincos.sv
// Self-checking bench for cordic_sincos: directed angles, bus release, reset abort,
// restart from DONE and randomized bit-exact comparison against an iteration model.
module tb_cordic_sincos;

  localparam int          N   = 16;
  localparam logic [31:0] PAT = 32'hA5C3_5A3C;

  logic clk, rst_n;
  wire  [31:0] result;
  int   checks, failures;
  int   atan_tab[16];

  cordic_sincos_if bus ();

  cordic_sincos #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .result (result)
  );

  // Another bus master takes the shared bus whenever the CORDIC is deselected.
  assign result = (bus.func > 4'd1) ? PAT : 32'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic void model(input logic signed [15:0] ang,
                                output logic signed [15:0] ms, output logic signed [15:0] mc);
    int x, y, z, xs, ys;
    z = ang;
`ifdef CORDIC_ANGLE_CLAMP_EN
    if (z > 25736) z = 25736;
    if (z < -25736) z = -25736;
`endif
    x = 9949;
    y = 0;
    for (int i = 0; i < N; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (z >= 0) begin
        x = wrap16(x - ys); y = wrap16(y + xs); z = wrap16(z - atan_tab[i]);
      end else begin
        x = wrap16(x + ys); y = wrap16(y - xs); z = wrap16(z + atan_tab[i]);
      end
    end
    ms = y[15:0];
    mc = x[15:0];
  endfunction

  function automatic int ideal_sin(input logic signed [15:0] a);
    return int'($sin(real'(a) / 16384.0) * 16384.0);
  endfunction

  function automatic int ideal_cos(input logic signed [15:0] a);
    return int'($cos(real'(a) / 16384.0) * 16384.0);
  endfunction

  function automatic int absdiff(input logic [31:0] v, input int want);
    int d;
    d = int'($signed(v)) - want;
    return (d < 0) ? -d : d;
  endfunction

  // Loads an angle and waits (bounded) for done; reports edges from load and busy cycles.
  task automatic start_and_wait(input logic signed [15:0] a, output int edges,
                                output int bcnt, output logic first_done);
    @(negedge clk);
    bus.st = 1'b1;
    bus.angle_in = a;
    @(negedge clk);
    bus.st = 1'b0;
    bus.angle_in = 16'($urandom);
    edges = 1;
    first_done = bus.done;
    bcnt = bus.busy ? 1 : 0;
    while (bus.done !== 1'b1 && edges < 64) begin
      @(negedge clk);
      edges++;
      if (bus.busy === 1'b1) bcnt++;
    end
  endtask

  task automatic read_results(output logic [31:0] s, output logic [31:0] c);
    bus.func = 4'd0;
    #1 s = result;
    bus.func = 4'd1;
    #1 c = result;
    bus.func = 4'd7;
  endtask

  task automatic test_reset;
    #2;
    bus.func = 4'd0;
    #1 checks++;
    if (result !== 32'd0) begin
      failures++; $display("FAIL reset_sin got=%h want=%h", result, 32'd0);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=%b%b want=00", bus.busy, bus.done);
    end
    bus.func = 4'd1;
    #1 checks++;
    if (result !== 32'd0) begin
      failures++; $display("FAIL reset_cos got=%h want=%h", result, 32'd0);
    end
    bus.func = 4'd7;
    #1 checks++;
    if (result !== PAT) begin
      failures++; $display("FAIL reset_release got=%h want=%h", result, PAT);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_angle;
    int e, b; logic fd; logic [31:0] s, c; logic signed [15:0] ms, mc;
    start_and_wait(16'sd0, e, b, fd);
    checks++;
    if (e != N + 1) begin
      failures++; $display("FAIL zero_latency got=%0d want=%0d", e, N + 1);
    end
    read_results(s, c);
    model(16'sd0, ms, mc);
    checks++;
    if (absdiff(c, 16384) > 4) begin
      failures++; $display("FAIL zero_cos got=%0d want=16384+-4", $signed(c));
    end
    checks++;
    if (absdiff(s, 0) > 4) begin
      failures++; $display("FAIL zero_sin got=%0d want=0+-4", $signed(s));
    end
    checks++;
    if (s !== {{16{ms[15]}}, ms} || c !== {{16{mc[15]}}, mc}) begin
      failures++; $display("FAIL zero_exact got=%h/%h want=%h/%h", s, c, ms, mc);
    end
  endtask

  task automatic test_pi4;
    int e, b; logic fd; logic [31:0] s, c;
    start_and_wait(16'sd12868, e, b, fd);
    checks++;
    if (b != N) begin
      failures++; $display("FAIL pi4_busy_cycles got=%0d want=%0d", b, N);
    end
    read_results(s, c);
    checks++;
    if (absdiff(s, 11585) > 4 || absdiff(c, 11585) > 4) begin
      failures++; $display("FAIL pi4_sincos got=%0d/%0d want=11585+-4", $signed(s), $signed(c));
    end
    checks++;
    if (absdiff(s, ideal_sin(16'sd12868)) > 4) begin
      failures++; $display("FAIL pi4_ideal got=%0d want=%0d", $signed(s), ideal_sin(16'sd12868));
    end
  endtask

  task automatic test_neg_pi2;
    int e, b; logic fd; logic [31:0] s, c;
    start_and_wait(-16'sd25736, e, b, fd);
    read_results(s, c);
    checks++;
    if (absdiff(s, -16384) > 4 || s[31:16] !== 16'hFFFF) begin
      failures++; $display("FAIL negpi2_sin got=%h want=FFFFC000+-4", s);
    end
    checks++;
    if (absdiff(c, 0) > 4) begin
      failures++; $display("FAIL negpi2_cos got=%0d want=0+-4", $signed(c));
    end
  endtask

  task automatic test_bus_release;
    int e; logic [31:0] s; logic signed [15:0] ms, mc;
    @(negedge clk);
    bus.st = 1'b1;
    bus.angle_in = 16'sd5000;
    @(negedge clk);
    bus.st = 1'b0;
    bus.func = 4'd0;
    #1 checks++;
    if (result !== 32'd0) begin
      failures++; $display("FAIL func0_before_done got=%h want=%h", result, 32'd0);
    end
    bus.func = 4'd5;
    #1 checks++;
    if (result !== PAT) begin
      failures++; $display("FAIL release_in_run got=%h want=%h", result, PAT);
    end
    e = 1;
    while (bus.done !== 1'b1 && e < 64) begin
      @(negedge clk);
      e++;
    end
    checks++;
    if (result !== PAT) begin
      failures++; $display("FAIL release_when_done got=%h want=%h", result, PAT);
    end
    model(16'sd5000, ms, mc);
    bus.func = 4'd0;
    #1 checks++;
    if (result !== {{16{ms[15]}}, ms}) begin
      failures++; $display("FAIL bus_sin got=%h want=%h", result, {{16{ms[15]}}, ms});
    end
    bus.func = 4'd7;
    s = result;
  endtask

  task automatic test_reset_mid_run;
    int e, b, seen; logic fd; logic [31:0] s, c; logic signed [15:0] ms, mc, a;
    @(negedge clk);
    bus.st = 1'b1;
    bus.angle_in = 16'sd7000;
    @(negedge clk);
    bus.st = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL abort_flags got=%b%b want=00", bus.busy, bus.done);
    end
    bus.func = 4'd0;
    #1 checks++;
    if (result !== 32'd0) begin
      failures++; $display("FAIL abort_result got=%h want=%h", result, 32'd0);
    end
    bus.func = 4'd7;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL no_done_after_abort got=%0d want=0", seen);
    end
    a = 16'($urandom_range(0, 51472)) - 16'sd25736;
    start_and_wait(a, e, b, fd);
    read_results(s, c);
    model(a, ms, mc);
    checks++;
    if (s[15:0] !== ms || c[15:0] !== mc || e != N + 1) begin
      failures++; $display("FAIL after_abort got=%h/%h/%0d want=%h/%h/%0d", s[15:0], c[15:0], e,
                           ms, mc, N + 1);
    end
  endtask

  task automatic test_back_to_back;
    int e, b; logic fd; logic [31:0] s, c; logic signed [15:0] ms, mc;
    @(negedge clk);
    bus.st = 1'b1;
    bus.angle_in = 16'sd3000;
    @(negedge clk);
    bus.st = 1'b0;
    bus.angle_in = -16'sd20000;
    e = 1;
    while (bus.done !== 1'b1 && e < 64) begin
      @(negedge clk);
      e++;
      bus.st = (e == 3);
    end
    bus.st = 1'b0;
    checks++;
    if (e != N + 1) begin
      failures++; $display("FAIL st_in_run_latency got=%0d want=%0d", e, N + 1);
    end
    read_results(s, c);
    model(16'sd3000, ms, mc);
    checks++;
    if (s[15:0] !== ms || c[15:0] !== mc) begin
      failures++; $display("FAIL st_in_run_result got=%h/%h want=%h/%h", s[15:0], c[15:0], ms, mc);
    end
    start_and_wait(-16'sd9000, e, b, fd);
    checks++;
    if (fd !== 1'b0 || e != N + 1) begin
      failures++; $display("FAIL restart_done got=%b/%0d want=0/%0d", fd, e, N + 1);
    end
    read_results(s, c);
    model(-16'sd9000, ms, mc);
    checks++;
    if (s[15:0] !== ms || c[15:0] !== mc) begin
      failures++; $display("FAIL restart_result got=%h/%h want=%h/%h", s[15:0], c[15:0], ms, mc);
    end
  endtask

  task automatic test_random;
    int e, b; logic fd; logic [31:0] s, c; logic signed [15:0] ms, mc, a;
    for (int k = 0; k < 24; k++) begin
      a = 16'($urandom);
      start_and_wait(a, e, b, fd);
      read_results(s, c);
      model(a, ms, mc);
      checks++;
      if (s !== {{16{ms[15]}}, ms} || c !== {{16{mc[15]}}, mc} || e != N + 1) begin
        failures++;
        $display("FAIL random angle=%0d got=%h/%h/%0d want=%h/%h/%0d", a, s, c, e, ms, mc, N + 1);
      end
    end
  endtask

  task automatic test_wide_angle;
    int e, b; logic fd; logic [31:0] s, c; logic signed [15:0] ms, mc;
    start_and_wait(16'sd30000, e, b, fd);
    read_results(s, c);
    model(16'sd30000, ms, mc);
`ifdef CORDIC_ANGLE_CLAMP_EN
    checks++;
    if (absdiff(s, 16384) > 4) begin
      failures++; $display("FAIL clamp_sin got=%0d want=16384+-4", $signed(s));
    end
`endif
    checks++;
    if (s[15:0] !== ms || c[15:0] !== mc) begin
      failures++; $display("FAIL wide_exact got=%h/%h want=%h/%h", s[15:0], c[15:0], ms, mc);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) begin
      atan_tab[i] = int'($atan(1.0 / real'(1 << i)) * 16384.0);
    end
    rst_n = 1'b0;
    bus.st = 1'b0;
    bus.angle_in = '0;
    bus.func = 4'd7;
    test_reset;
    test_zero_angle;
    test_pi4;
    test_neg_pi2;
    test_bus_release;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
    test_wide_angle;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_sincos.md
CORDIC_SINCOS -- requirements
Module: cordic_sincos

Interface
REQ-001 Parameter: N, 16, number of CORDIC iterations; supported range 1..16.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  rising-edge clock for all sequential logic.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: st  input  1  start request, sampled on rising clk.
REQ-006 Port: angle_in  input  16  signed angle in radians, Q2.14 (16384 = 1.0 rad).
REQ-007 Port: func  input  4  shared-bus select: 0 = sine, 1 = cosine, any other value = release the bus.
REQ-008 Port: busy  output  1  high while iterations run.
REQ-009 Port: done  output  1  high while the results are valid.
REQ-010 Port: result  output  32  shared bus: the selected result, or high-Z.

Function
REQ-011 The block SHALL compute sin and cos by rotation-mode CORDIC on 16-bit signed Q2.14 registers x, y and z.
REQ-012 The arctan table SHALL hold round(atan(2^-i)*16384) for i = 0..15; entry 0 = 12868.
REQ-013 FSM states SHALL be IDLE=0, RUN=1, DONE=2; state 3 is unreachable and returns to IDLE.
REQ-014 IDLE/DONE with st=1 at a clk edge: load x=9949 (K), y=0, z=angle_in, i=0; go to RUN.
REQ-015 IDLE/DONE with st=0: hold state and registers.
REQ-016 RUN, each edge: let d=+1 if z>=0, else -1.
REQ-017 RUN update: x<=x-d*(y>>>i), y<=y+d*(x>>>i), z<=z-d*atan[i], i<=i+1.
REQ-018 Shifts SHALL be arithmetic; adds SHALL wrap in 16 bits; there is no saturation.
REQ-019 The iteration counter SHALL be compared with N before updating; the edge that completes iteration N-1 moves the FSM to DONE.
REQ-020 Latency: st sampled at edge E0; iterations at E1..EN; done=1 from EN until the next load.
REQ-021 st during RUN SHALL be ignored; angle_in is sampled only at load.
REQ-022 st=1 in DONE SHALL restart (REQ-014); done falls at that edge.
REQ-023 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-024 Results: sin = final y, cos = final x, each sign-extended to 32 bits on result.
REQ-025 result SHALL be high-Z when func is not 0 or 1.
REQ-026 result SHALL be 0 when func is 0 or 1 and done=0.
REQ-027 Accuracy: for |angle_in| <= 25736 (pi/2), with N=16, each result SHALL be within ±4 LSB of round(f(angle)*16384).

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, x=y=z=0, i=0, busy=0 and done=0.
REQ-029 During reset, result SHALL follow REQ-025 and REQ-026.
REQ-030 Reset asserted mid-RUN SHALL abort the computation; no done pulse follows deassertion.
REQ-031 After rst_n rises, the first st=1 sampled SHALL start a normal computation.

Configuration
REQ-032 Macro CORDIC_ANGLE_CLAMP_EN, when defined, SHALL clamp angle_in at load: angle_in > 25736 loads z=25736, and angle_in < -25736 loads z=-25736.
REQ-033 Without CORDIC_ANGLE_CLAMP_EN, angle_in SHALL be loaded unmodified.
REQ-034 Without the macro, results for |angle_in| > 25736 SHALL be exactly the REQ-017 iteration output; no accuracy is required for those inputs.

Verification
REQ-035 angle_in=0, st pulse, func=1 then func=0 -> done after N+1 edges; cos within 16384±4; sin within 0±4.
REQ-036 angle_in=12868 (pi/4) -> sin and cos each within 11585±4; busy high for exactly N cycles.
REQ-037 angle_in=-25736 (-pi/2) -> sin within -16384±4 (result 0xFFFFC000±4); cos within 0±4.
REQ-038 func=5 at any time -> result all Z; func=0 before done -> result=0.
REQ-039 rst_n low at cycle 5 of RUN -> done=0 and busy=0 immediately; no done until a new st; a new st yields correct values.
REQ-040 With CORDIC_ANGLE_CLAMP_EN: angle_in=30000 -> sin within 16384±4. Without it: the 16-bit outputs equal the bit-exact REQ-017 reference model.
